// File: rtl/sw_conditioner.sv
// Switch conditioner: 2-flop synchronizer, shared tick prescaler, per-bit debounce with edge pulses.
// Optional auto-repeat of rise pulses on held-high bits when SW_COND_AUTOREPEAT_EN is defined.
module sw_conditioner #(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 8,
    parameter int REPEAT_TICKS = 250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] sw_rise_o,
    output logic [WIDTH-1:0] sw_fall_o,
    output logic             any_change_o
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int CNT_W = $clog2(STABLE_TICKS);

    if (TICK_DIV < 2 || STABLE_TICKS < 2 || STABLE_TICKS > 255 || REPEAT_TICKS < 1) begin : g_bad_param
        $error("sw_conditioner: illegal parameter value");
    end

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] synced;
    logic [PRE_W-1:0] prescale;
    logic             tick;

    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] level_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    assign tick = (prescale == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            synced    <= '0;
            prescale  <= '0;
        end else begin
            sync_meta <= sw_i;
            synced    <= sync_meta;
            prescale  <= tick ? '0 : prescale + 1'b1;
        end
    end

`ifdef SW_COND_AUTOREPEAT_EN
    localparam int REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

    logic [REP_W-1:0] rep      [WIDTH];
    logic [REP_W-1:0] rep_next [WIDTH];
`endif

    // The counter holds the number of consecutive differing samples seen so far;
    // the sample that would bring it to STABLE_TICKS accepts the new level instead.
    always_comb begin
        level_next = sw_o;
        rise_next  = '0;
        fall_next  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i];
            if (tick) begin
                if (synced[i] == sw_o[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CNT_W'(STABLE_TICKS - 1)) begin
                    cnt_next[i]   = '0;
                    level_next[i] = synced[i];
                    rise_next[i]  = synced[i];
                    fall_next[i]  = ~synced[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
`ifdef SW_COND_AUTOREPEAT_EN
            rep_next[i] = rep[i];
            if (!sw_o[i] || (level_next[i] != sw_o[i])) begin
                rep_next[i] = '0;
            end else if (tick) begin
                if (rep[i] == REP_W'(REPEAT_TICKS - 1)) begin
                    rep_next[i]  = '0;
                    rise_next[i] = 1'b1;
                end else begin
                    rep_next[i] = rep[i] + 1'b1;
                end
            end
`endif
        end
    end

    // Pulses are registered alongside sw_o so they line up with the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_o         <= '0;
            sw_rise_o    <= '0;
            sw_fall_o    <= '0;
            any_change_o <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
`ifdef SW_COND_AUTOREPEAT_EN
                rep[i] <= '0;
`endif
            end
        end else begin
            sw_o         <= level_next;
            sw_rise_o    <= rise_next;
            sw_fall_o    <= fall_next;
            any_change_o <= |(rise_next | fall_next);
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
`ifdef SW_COND_AUTOREPEAT_EN
                rep[i] <= rep_next[i];
`endif
            end
        end
    end

endmodule
